gf2_poly_div_seq: RTL

//  Sequential carry-less (GF(2)[x]) polynomial divider; the inverse of the 8x8 carry-less multiplier.

---
 rtl/gf2_pkg.sv | 22 ++
 rtl/gf2_div_step.sv | 33 +++
 rtl/gf2_poly_div_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/gf2_pkg.sv
// Shared definitions for the GF(2)[x] divider and the carry-less multiplier benches.
package gf2_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Carry-less product of two polynomials of up to 16 coefficients each.
    function automatic logic [31:0] clmul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) acc = acc ^ ({16'd0, a} << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf2_div_step.sv
// One long-division step: the coefficient of x^(NW-1-k) in the working
// dividend becomes quotient bit k, and the aligned divisor is cancelled out.
module gf2_div_step
    import gf2_pkg::*;
#(
    parameter  int DW = DW_DEFAULT,
    localparam int NW = 2 * DW - 1,
    localparam int CW = $clog2(DW + 1)
) (
    input  logic [NW-1:0] w,
    input  logic [DW-1:0] d,
    input  logic [CW-1:0] k,
    output logic [NW-1:0] w_next,
    output logic          qbit
);

    logic [NW-1:0] d_ext;

    assign d_ext = {{(DW - 1){1'b0}}, d};

    // Select the leading coefficient for step k and subtract (XOR) the shifted divisor.
    always_comb begin
        qbit   = 1'b0;
        w_next = w;
        for (int i = 0; i < DW; i++) begin
            if (k == CW'(i)) begin
                qbit = w[NW-1-i];
                if (w[NW-1-i]) w_next = w ^ (d_ext << (DW - 1 - i));
            end
        end
    end

endmodule

// File: rtl/gf2_poly_div_seq.sv
// Sequential carry-less polynomial divider: one quotient bit per clock,
// MSB first, with a valid/ready request side and a valid/ready result side.
module gf2_poly_div_seq
    import gf2_pkg::*;
#(
    parameter  int DW = DW_DEFAULT,
    localparam int NW = 2 * DW - 1,
    localparam int CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [DW-2:0] remainder,
    output logic          err
);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [NW-1:0] w;
    logic [NW-1:0] w_step;
    logic [DW-1:0] d;
    logic [DW-1:0] q;
    logic          qbit;
    logic          accept;
    logic          last_step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last_step = (state == BUSY) && (cnt == CW'(DW - 1));

    gf2_div_step #(.DW(DW)) u_step (
        .w      (w),
        .d      (d),
        .k      (cnt),
        .w_next (w_step),
        .qbit   (qbit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: non-monic divisors skip straight to DONE with err set.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = divisor[DW-1] ? BUSY : DONE;
            BUSY: if (cnt == CW'(DW - 1)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Step counter: cleared on accept, counts BUSY edges up to DW and stops there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               cnt <= '0;
        else if (accept)          cnt <= '0;
        else if (state == BUSY)   cnt <= cnt + CW'(1);
    end

    // Working dividend, divisor and partial quotient; only meaningful in BUSY.
    always_ff @(posedge clk) begin
        if (accept) begin
            w <= dividend;
            d <= divisor;
            q <= '0;
        end else if (state == BUSY) begin
            w <= w_step;
            q <= {q[DW-2:0], qbit};
        end
    end

    // Result registers: written on a rejected divisor or on the final step, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            err       <= 1'b0;
        end else if (accept && !divisor[DW-1]) begin
            quotient  <= '0;
            remainder <= '0;
            err       <= 1'b1;
        end else if (last_step) begin
            quotient  <= {q[DW-2:0], qbit};
            remainder <= w_step[DW-2:0];
            err       <= 1'b0;
        end
    end

    // After the last step every coefficient at or above x^(DW-1) must have been cancelled.
    always_ff @(posedge clk) begin
        if (rst_n && last_step) assert (w_step[NW-1:DW-1] == '0);
    end

endmodule
